// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin sharing of one combinational ALU between two requesters
// Optional macro ALU_ARB_STATS_EN adds grant and stall counters.
module alu_share_arbiter #(
   parameter int DATA_W     = 32,
   parameter int OP_W       = 4,
   parameter bit RESET_PRIO = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              r0_valid,
   output logic              r0_ready,
   input  logic [DATA_W-1:0] r0_a,
   input  logic [DATA_W-1:0] r0_b,
   input  logic [OP_W-1:0]   r0_op,
   output logic              r0_rsp_valid,
   input  logic              r0_rsp_ready,
   output logic [DATA_W-1:0] r0_result,
   output logic [2:0]        r0_flags,
   input  logic              r1_valid,
   output logic              r1_ready,
   input  logic [DATA_W-1:0] r1_a,
   input  logic [DATA_W-1:0] r1_b,
   input  logic [OP_W-1:0]   r1_op,
   output logic              r1_rsp_valid,
   input  logic              r1_rsp_ready,
   output logic [DATA_W-1:0] r1_result,
   output logic [2:0]        r1_flags,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [OP_W-1:0]   alu_op,
   input  logic [DATA_W-1:0] alu_result,
   input  logic              alu_overflow,
   input  logic              alu_carryout,
   input  logic              alu_zero,
`ifdef ALU_ARB_STATS_EN
   output logic [31:0]       grant_cnt0,
   output logic [31:0]       grant_cnt1,
   output logic [31:0]       stall_cnt,
`endif
   output logic              busy,
   output logic              owner
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t            state;
   logic              ptr;
   logic              owner_q;
   logic              busy_q;
   logic              rsp0_q;
   logic              rsp1_q;
   logic [DATA_W-1:0] a_q;
   logic [DATA_W-1:0] b_q;
   logic [OP_W-1:0]   op_q;
   logic [DATA_W-1:0] res_q;
   logic [2:0]        flags_q;
   logic              winner;
   logic              grant;
   logic              rsp_ack;

   // Pointer only matters under contention; a lone requester always wins.
   assign winner   = (r0_valid && r1_valid) ? ptr : r1_valid;
   assign r0_ready = !rst && (state == IDLE) && r0_valid && !winner;
   assign r1_ready = !rst && (state == IDLE) && r1_valid && winner;
   assign grant    = r0_ready || r1_ready;
   assign rsp_ack  = owner_q ? r1_rsp_ready : r0_rsp_ready;

   assign alu_a        = a_q;
   assign alu_b        = b_q;
   assign alu_op       = op_q;
   assign r0_result    = res_q;
   assign r1_result    = res_q;
   assign r0_flags     = flags_q;
   assign r1_flags     = flags_q;
   assign r0_rsp_valid = rsp0_q;
   assign r1_rsp_valid = rsp1_q;
   assign busy         = busy_q;
   assign owner        = owner_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         ptr     <= RESET_PRIO;
         owner_q <= RESET_PRIO;
         busy_q  <= 1'b0;
         rsp0_q  <= 1'b0;
         rsp1_q  <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
         res_q   <= '0;
         flags_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant) begin
                  a_q     <= winner ? r1_a : r0_a;
                  b_q     <= winner ? r1_b : r0_b;
                  op_q    <= winner ? r1_op : r0_op;
                  owner_q <= winner;
                  ptr     <= ~winner;
                  busy_q  <= 1'b1;
                  state   <= EXEC;
               end
            end
            EXEC: begin
               res_q   <= alu_result;
               flags_q <= {alu_overflow, alu_carryout, alu_zero};
               rsp0_q  <= ~owner_q;
               rsp1_q  <= owner_q;
               state   <= RESP;
            end
            RESP: begin
               if (rsp_ack) begin
                  rsp0_q <= 1'b0;
                  rsp1_q <= 1'b0;
                  busy_q <= 1'b0;
                  state  <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef ALU_ARB_STATS_EN
   // A cycle where both requesters are stalled still counts once.
   always_ff @(posedge clk) begin
      if (rst) begin
         grant_cnt0 <= '0;
         grant_cnt1 <= '0;
         stall_cnt  <= '0;
      end else begin
         if (r0_ready) grant_cnt0 <= grant_cnt0 + 32'd1;
         if (r1_ready) grant_cnt1 <= grant_cnt1 + 32'd1;
         if ((r0_valid && !r0_ready) || (r1_valid && !r1_ready))
            stall_cnt <= stall_cnt + 32'd1;
      end
   end
`else
   // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - directed vector bench for alu_share_arbiter
// Supports builds with or without ALU_ARB_STATS_EN.
module tb_alu_share_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        r0_valid, r0_ready, r0_rsp_valid, r0_rsp_ready;
   logic [31:0] r0_a, r0_b, r0_result;
   logic [3:0]  r0_op;
   logic [2:0]  r0_flags;
   logic        r1_valid, r1_ready, r1_rsp_valid, r1_rsp_ready;
   logic [31:0] r1_a, r1_b, r1_result;
   logic [3:0]  r1_op;
   logic [2:0]  r1_flags;
   logic [31:0] alu_a, alu_b, alu_result;
   logic [3:0]  alu_op;
   logic        alu_overflow, alu_carryout, alu_zero;
   logic        busy, owner;
`ifdef ALU_ARB_STATS_EN
   logic [31:0] grant_cnt0, grant_cnt1, stall_cnt;
`endif

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   alu_share_arbiter #(.DATA_W(32), .OP_W(4), .RESET_PRIO(1'b0)) dut (
      .clk(clk), .rst(rst),
      .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_a(r0_a), .r0_b(r0_b), .r0_op(r0_op),
      .r0_rsp_valid(r0_rsp_valid), .r0_rsp_ready(r0_rsp_ready), .r0_result(r0_result), .r0_flags(r0_flags),
      .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_a(r1_a), .r1_b(r1_b), .r1_op(r1_op),
      .r1_rsp_valid(r1_rsp_valid), .r1_rsp_ready(r1_rsp_ready), .r1_result(r1_result), .r1_flags(r1_flags),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
      .alu_overflow(alu_overflow), .alu_carryout(alu_carryout), .alu_zero(alu_zero),
`ifdef ALU_ARB_STATS_EN
      .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1), .stall_cnt(stall_cnt),
`endif
      .busy(busy), .owner(owner)
   );

   // Stand-in ALU: AND=0000 OR=0001 ADD=0010 SUB=0110 (carry = borrow), others 0.
   logic [32:0] sum;
   always_comb begin
      sum = '0;
      alu_result = '0;
      alu_overflow = 1'b0;
      alu_carryout = 1'b0;
      alu_zero = 1'b0;
      case (alu_op)
         4'b0000: alu_result = alu_a & alu_b;
         4'b0001: alu_result = alu_a | alu_b;
         4'b0010: begin
            sum = {1'b0, alu_a} + {1'b0, alu_b};
            alu_result = sum[31:0];
            alu_carryout = sum[32];
            alu_overflow = (alu_a[31] == alu_b[31]) && (sum[31] != alu_a[31]);
         end
         4'b0110: begin
            alu_result = alu_a - alu_b;
            alu_carryout = alu_a < alu_b;
            alu_overflow = (alu_a[31] != alu_b[31]) && (alu_result[31] != alu_a[31]);
         end
         default: alu_result = '0;
      endcase
      if (alu_op inside {4'b0000, 4'b0001, 4'b0010, 4'b0110})
         alu_zero = (alu_result == 32'd0);
   end

   typedef struct {
      bit          r;
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  op;
      logic [31:0] res;
      logic [2:0]  fl;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_rsp(input bit r, input string nm);
      int n = 0;
      while (!(r ? r1_rsp_valid : r0_rsp_valid) && n < 20) begin
         step();
         n++;
      end
      chk({nm, " rsp_timeout"}, n < 20, 1);
   endtask

   task automatic do_txn(input bit r, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                         input logic [31:0] er, input logic [2:0] ef, input string nm);
      int lat;
      if (r) begin r1_valid = 1; r1_a = a; r1_b = b; r1_op = op; end
      else   begin r0_valid = 1; r0_a = a; r0_b = b; r0_op = op; end
      #1;
      chk({nm, " ready"}, r ? r1_ready : r0_ready, 1);
      chk({nm, " other_ready"}, r ? r0_ready : r1_ready, 0);
      step();
      r0_valid = 0;
      r1_valid = 0;
      lat = 1;
      while (!(r ? r1_rsp_valid : r0_rsp_valid) && lat < 20) begin
         step();
         lat++;
      end
      chk({nm, " latency"}, lat, 2);
      chk({nm, " result"}, r ? r1_result : r0_result, er);
      chk({nm, " flags"}, r ? r1_flags : r0_flags, ef);
      chk({nm, " other_rsp_valid"}, r ? r0_rsp_valid : r1_rsp_valid, 0);
      chk({nm, " owner"}, owner, r);
      chk({nm, " alu_op"}, alu_op, op);
      if (r) r1_rsp_ready = 1; else r0_rsp_ready = 1;
      step();
      r0_rsp_ready = 0;
      r1_rsp_ready = 0;
      chk({nm, " rsp_drop"}, r ? r1_rsp_valid : r0_rsp_valid, 0);
      chk({nm, " idle"}, busy, 0);
   endtask

   initial begin
      int ng;
      int cyc;
      bit order[5];

      vecs[0] = '{1'b0, 32'd5,          32'd7,          4'b0010, 32'd12,         3'b000};
      vecs[1] = '{1'b1, 32'h7FFF_FFFF,  32'd1,          4'b0010, 32'h8000_0000,  3'b100};
      vecs[2] = '{1'b0, 32'd3,          32'd3,          4'b0110, 32'd0,          3'b001};
      vecs[3] = '{1'b1, 32'h0000_00F0,  32'h0000_000F,  4'b0001, 32'h0000_00FF,  3'b000};
      vecs[4] = '{1'b0, 32'hFFFF_FFFF,  32'd1,          4'b0010, 32'd0,          3'b011};
      vecs[5] = '{1'b1, 32'h0000_F0F0,  32'h0000_0FF0,  4'b0000, 32'h0000_00F0,  3'b000};
      vecs[6] = '{1'b0, 32'd9,          32'd4,          4'b1111, 32'd0,          3'b000};
      vecs[7] = '{1'b1, 32'd1,          32'd2,          4'b0110, 32'hFFFF_FFFF,  3'b010};

      rst = 1;
      r0_valid = 0; r0_a = 0; r0_b = 0; r0_op = 0; r0_rsp_ready = 0;
      r1_valid = 0; r1_a = 0; r1_b = 0; r1_op = 0; r1_rsp_ready = 0;
      step();
      r0_valid = 1;
      step();
      chk("reset r0_ready", r0_ready, 0);
      chk("reset busy", busy, 0);
      chk("reset owner", owner, 0);
      chk("reset rsp_valid", {r0_rsp_valid, r1_rsp_valid}, 0);
      chk("reset alu_in", {alu_a, alu_b, alu_op}, 0);
      chk("reset result", {r0_result, r0_flags}, 0);
      r0_valid = 0;
      rst = 0;
      step();

      for (int i = 0; i < 8; i++)
         do_txn(vecs[i].r, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].res, vecs[i].fl, $sformatf("vec%0d", i));

      // Contention straight after reset: R0 first, R1 granted in the next IDLE cycle.
      rst = 1; step(); rst = 0;
      r0_valid = 1; r0_a = 3;    r0_b = 3;    r0_op = 4'b0110;
      r1_valid = 1; r1_a = 'hF0; r1_b = 'h0F; r1_op = 4'b0001;
      #1;
      chk("cont r0_ready", r0_ready, 1);
      chk("cont r1_ready", r1_ready, 0);
      step();
      r0_valid = 0;
      chk("cont exec r1_ready", r1_ready, 0);
      step();
      chk("cont r0 rsp", {r0_rsp_valid, r0_result, r0_flags}, {1'b1, 32'd0, 3'b001});
      chk("cont r1 waits", r1_ready, 0);
      r0_rsp_ready = 1;
      step();
      r0_rsp_ready = 0;
      chk("cont r1 granted", r1_ready, 1);
      step();
      r1_valid = 0;
      wait_rsp(1, "cont r1");
      chk("cont r1 result", r1_result, 32'hFF);
      r1_rsp_ready = 1; step(); r1_rsp_ready = 0;

      // Five back-to-back contended rounds.
      rst = 1; step(); rst = 0;
      r0_valid = 1; r0_a = 1; r0_b = 1; r0_op = 4'b0010;
      r1_valid = 1; r1_a = 2; r1_b = 2; r1_op = 4'b0010;
      r0_rsp_ready = 1; r1_rsp_ready = 1;
      #1;
      ng = 0;
      cyc = 0;
      while (ng < 5 && cyc < 100) begin
         if (r0_rsp_valid) chk("rr r0 result", r0_result, 32'd2);
         if (r1_rsp_valid) chk("rr r1 result", r1_result, 32'd4);
         if (r0_ready) begin order[ng] = 0; ng++; end
         else if (r1_ready) begin order[ng] = 1; ng++; end
         step();
         cyc++;
      end
      chk("rr grants", ng, 5);
      chk("rr cycles", cyc, 13);
      for (int i = 0; i < 5; i++)
         chk($sformatf("rr order%0d", i), order[i], i % 2);
`ifdef ALU_ARB_STATS_EN
      chk("rr grant_cnt0", grant_cnt0, 3);
      chk("rr grant_cnt1", grant_cnt1, 2);
      chk("rr stall_cnt", stall_cnt, 13);
`endif
      r0_valid = 0;
      r1_valid = 0;
      wait_rsp(0, "rr last");
      step();
      r0_rsp_ready = 0; r1_rsp_ready = 0;
      chk("rr done", busy, 0);

      // Response backpressure on R1 while R0 waits.
      r1_valid = 1; r1_a = 10; r1_b = 20; r1_op = 4'b0010;
      #1;
      chk("bp r1_ready", r1_ready, 1);
      step();
      r1_valid = 0;
      r0_valid = 1; r0_a = 'hFF; r0_b = 'h0F; r0_op = 4'b0000;
      wait_rsp(1, "bp");
      for (int i = 0; i < 10; i++) begin
         chk("bp hold", {r1_rsp_valid, r1_result, r1_flags, busy, r0_ready}, {1'b1, 32'd30, 3'b000, 1'b1, 1'b0});
         step();
      end
      r1_rsp_ready = 1;
      #1;
      chk("bp ack cycle r0_ready", r0_ready, 0);
      step();
      r1_rsp_ready = 0;
      chk("bp released", {r1_rsp_valid, busy, r0_ready}, {1'b0, 1'b0, 1'b1});
      step();
      r0_valid = 0;
      wait_rsp(0, "bp r0");
      chk("bp r0 result", r0_result, 32'h0F);
      r0_rsp_ready = 1; step(); r0_rsp_ready = 0;

      // Reset during EXEC discards the transaction and restores the pointer.
      r0_valid = 1; r0_a = 9; r0_b = 9; r0_op = 4'b0010;
      #1;
      step();
      chk("mid exec busy", busy, 1);
      rst = 1;
      #1;
      chk("mid rst r0_ready", r0_ready, 0);
      step();
      r0_valid = 0;
      rst = 0;
      #1;
      chk("mid reset outputs", {busy, owner, r0_rsp_valid, r1_rsp_valid}, 0);
      chk("mid reset regs", {alu_a, alu_b, alu_op, r0_result, r0_flags}, 0);
      for (int i = 0; i < 4; i++) begin
         chk("mid no rsp", {r0_rsp_valid, r1_rsp_valid}, 0);
         step();
      end
      r0_valid = 1; r0_a = 4; r0_b = 6; r0_op = 4'b0010;
      r1_valid = 1; r1_a = 1; r1_b = 1; r1_op = 4'b0010;
      #1;
      chk("mid ptr r0_ready", r0_ready, 1);
      chk("mid ptr r1_ready", r1_ready, 0);
      r1_valid = 0;
      do_txn(0, 32'd4, 32'd6, 4'b0010, 32'd10, 3'b000, "post_reset r0");
      do_txn(1, 32'd8, 32'd8, 4'b0110, 32'd0, 3'b001, "post_reset r1");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
